fp_round_pack: RTL and testbench

FP_ROUND_PACK -- requirements
Module: fp_round_pack

---
 rtl/fp_round_pack.sv | 175 +++++++++++++++++
 tb/tb_fp_round_pack.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// Round-and-pack back end for the FP adder: takes a normalized significand and
// double-biased exponent, rounds to double or single, and packs a 64-bit result.
module fp_round_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        db,
   input  logic [1:0]  RM,
   input  logic        ss,
   input  logic [10:0] es,
   input  logic [56:0] fs,
   input  logic        in_nan,
   input  logic        in_inf,
   input  logic        in_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] fp_out,
   output logic        ovf,
   output logic        unf,
   output logic        inx
);

   typedef enum logic [1:0] {IDLE, RND, PCK, OUT} state_t;

   typedef struct packed {
      logic        db;
      logic [1:0]  rm;
      logic        ss;
      logic [10:0] es;
      logic [56:0] fs;
      logic        nan;
      logic        inf;
      logic        zero;
   } op_t;

   state_t state, state_nxt;
   op_t    op;

   logic                guard, sticky, lsb, inc, carry;
   logic [51:0]         frac_d;
   logic [22:0]         frac_s;
   logic [51:0]         frac_rnd;
   logic signed [12:0]  exp_rnd;

   logic signed [12:0]  r_exp;
   logic [51:0]         r_frac;
   logic                r_inx;

   logic                ovf_c, unf_c, to_inf;
   logic [63:0]         inf_v, max_v, zero_v, norm_v, pk_out;
   logic                pk_ovf, pk_unf, pk_inx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RND;
         end
         RND: state_nxt = PCK;
         PCK: state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         op <= '0;
      else if (state == IDLE && in_valid)
         op <= '{db: db, rm: RM, ss: ss, es: es, fs: fs,
                 nan: in_nan, inf: in_inf, zero: in_zero};
   end

   // The fraction add wraps to zero exactly when the whole significand was all
   // ones, which is the 1.0 renormalization; carry then bumps the exponent.
   always_comb begin
      if (op.db) begin
         guard  = op.fs[3];
         sticky = |op.fs[2:0];
         lsb    = op.fs[4];
      end else begin
         guard  = op.fs[32];
         sticky = |op.fs[31:0];
         lsb    = op.fs[33];
      end
      unique case (op.rm)
         2'b00:   inc = guard & (sticky | lsb);
         2'b01:   inc = 1'b0;
         2'b10:   inc = (guard | sticky) & ~op.ss;
         default: inc = (guard | sticky) & op.ss;
      endcase
      frac_d = op.fs[55:4] + {51'd0, inc};
      frac_s = op.fs[55:33] + {22'd0, inc};
      if (op.db) begin
         carry    = inc & (&op.fs[56:4]);
         frac_rnd = frac_d;
      end else begin
         carry    = inc & (&op.fs[56:33]);
         frac_rnd = {29'd0, frac_s};
      end
      exp_rnd = $signed({2'b00, op.es}) - (op.db ? 13'sd0 : 13'sd896)
                + $signed({12'd0, carry});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp  <= '0;
         r_frac <= '0;
         r_inx  <= 1'b0;
      end else if (state == RND) begin
         r_exp  <= exp_rnd;
         r_frac <= frac_rnd;
         r_inx  <= guard | sticky;
      end
   end

   always_comb begin
      ovf_c  = op.db ? (r_exp >= 13'sd2047) : (r_exp >= 13'sd255);
      unf_c  = (r_exp <= 13'sd0);
      to_inf = (op.rm == 2'b00) | ((op.rm == 2'b10) & ~op.ss) | ((op.rm == 2'b11) & op.ss);
      inf_v  = op.db ? {op.ss, 11'h7FF, 52'd0} : {op.ss, 8'hFF, 23'd0, 32'd0};
      max_v  = op.db ? {op.ss, 11'h7FE, {52{1'b1}}} : {op.ss, 8'hFE, {23{1'b1}}, 32'd0};
      zero_v = {op.ss, 63'd0};
      norm_v = op.db ? {op.ss, r_exp[10:0], r_frac}
                     : {op.ss, r_exp[7:0], r_frac[22:0], 32'd0};
      pk_ovf = 1'b0;
      pk_unf = 1'b0;
      pk_inx = 1'b0;
      if (op.nan)
         pk_out = op.db ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000_0000_0000;
      else if (op.inf)
         pk_out = inf_v;
      else if (op.zero || op.fs == '0)
         pk_out = zero_v;
      else if (ovf_c) begin
         pk_out = to_inf ? inf_v : max_v;
         pk_ovf = 1'b1;
         pk_inx = 1'b1;
      end else if (unf_c) begin
         pk_out = zero_v;
         pk_unf = 1'b1;
         pk_inx = 1'b1;
      end else begin
         pk_out = norm_v;
         pk_inx = r_inx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fp_out <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
         inx    <= 1'b0;
      end else if (state == PCK) begin
         fp_out <= pk_out;
         ovf    <= pk_ovf;
         unf    <= pk_unf;
         inx    <= pk_inx;
      end
   end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack: stimulus pushes expected results, a
// monitor pops and compares on every out_valid & out_ready.
module tb_fp_round_pack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        db = 1'b0;
   logic [1:0]  RM = 2'b00;
   logic        ss = 1'b0;
   logic [10:0] es = '0;
   logic [56:0] fs = '0;
   logic        in_nan = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] fp_out;
   logic        ovf, unf, inx;

   typedef struct {
      string       name;
      logic [63:0] v;
      logic [2:0]  f;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   n_out = 0;

   fp_round_pack dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .db(db), .RM(RM), .ss(ss), .es(es), .fs(fs),
      .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .fp_out(fp_out), .ovf(ovf), .unf(unf), .inx(inx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         exp_t e;
         n_out++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: fp_out=%h flags=%b with nothing expected", fp_out, {ovf, unf, inx});
         end else begin
            e = exp_q.pop_front();
            if (fp_out !== e.v || {ovf, unf, inx} !== e.f) begin
               fails++;
               $display("FAIL %s: fp_out=%h ovf/unf/inx=%b, expected fp_out=%h ovf/unf/inx=%b",
                        e.name, fp_out, {ovf, unf, inx}, e.v, e.f);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   // Returns one time unit after the accept edge (block now in RND).
   task automatic send(input string nm, input logic d, input logic [1:0] rm, input logic s,
                       input logic [10:0] e, input logic [56:0] f, input logic [2:0] spc,
                       input logic [63:0] xv, input logic [2:0] xf, input bit push);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL %s_accept_timeout: in_ready=%b, expected 1", nm, in_ready);
         return;
      end
      db = d; RM = rm; ss = s; es = e; fs = f;
      {in_nan, in_inf, in_zero} = spc;
      in_valid = 1'b1;
      if (push) exp_q.push_back('{nm, xv, xf});
      @(posedge clk); #1;
      in_valid = 1'b0;
      {in_nan, in_inf, in_zero} = 3'b000;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (exp_q.size() != 0 || !in_ready) begin
         fails++;
         $display("FAIL %s_drain_timeout: %0d results outstanding, in_ready=%b", nm, exp_q.size(), in_ready);
      end
   endtask

   initial begin
      #1;
      check("reset_values", {in_ready, out_valid, ovf, unf, inx, fp_out}, {1'b1, 4'b0000, 64'd0});
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Latency: out_valid two edges after the accept edge.
      send("dbl_3.0", 1, 2'b00, 0, 11'h400, 57'h180000000000000, 3'b000, 64'h4008000000000000, 3'b000, 1);
      check("lat_rnd", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      check("lat_pck", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      check("lat_out", {63'd0, out_valid}, 64'd1);

      send("dbl_carry", 1, 2'b00, 0, 11'h3FF, 57'h1FFFFFFFFFFFFF8, 3'b000, 64'h4000000000000000, 3'b001, 1);
      send("dbl_ovf_rz", 1, 2'b01, 1, 11'h7FF, 57'h100000000000000, 3'b000, 64'hFFEFFFFFFFFFFFFF, 3'b101, 1);
      send("dbl_ovf_rne", 1, 2'b00, 1, 11'h7FF, 57'h100000000000000, 3'b000, 64'hFFF0000000000000, 3'b101, 1);
      send("dbl_ovf_rp_neg", 1, 2'b10, 1, 11'h7FF, 57'h100000000000000, 3'b000, 64'hFFEFFFFFFFFFFFFF, 3'b101, 1);
      send("dbl_carry_ovf", 1, 2'b00, 0, 11'h7FE, 57'h1FFFFFFFFFFFFF8, 3'b000, 64'h7FF0000000000000, 3'b101, 1);
      send("sgl_3.0", 0, 2'b00, 0, 11'h400, 57'h180000000000000, 3'b000, 64'h4040000000000000, 3'b000, 1);
      send("sgl_unf", 0, 2'b00, 0, 11'h380, 57'h180000000000000, 3'b000, 64'h0, 3'b011, 1);
      send("dbl_unf_neg", 1, 2'b00, 1, 11'h000, 57'h100000000000000, 3'b000, 64'h8000000000000000, 3'b011, 1);
      send("rne_tie_even", 1, 2'b00, 0, 11'h3FF, 57'h100000000000008, 3'b000, 64'h3FF0000000000000, 3'b001, 1);
      send("rne_tie_odd", 1, 2'b00, 0, 11'h3FF, 57'h100000000000018, 3'b000, 64'h3FF0000000000002, 3'b001, 1);
      send("rp_pos_sticky", 1, 2'b10, 0, 11'h3FF, 57'h100000000000001, 3'b000, 64'h3FF0000000000001, 3'b001, 1);
      send("rp_neg_sticky", 1, 2'b10, 1, 11'h3FF, 57'h100000000000001, 3'b000, 64'hBFF0000000000000, 3'b001, 1);
      send("rm_neg_sticky", 1, 2'b11, 1, 11'h3FF, 57'h100000000000001, 3'b000, 64'hBFF0000000000001, 3'b001, 1);
      send("rz_sticky", 1, 2'b01, 0, 11'h3FF, 57'h1FFFFFFFFFFFFFF, 3'b000, 64'h3FFFFFFFFFFFFFFF, 3'b001, 1);
      send("sgl_tie_even", 0, 2'b00, 0, 11'h3FF, 57'h100000100000000, 3'b000, 64'h3F80000000000000, 3'b001, 1);
      send("sgl_rnd_up", 0, 2'b00, 0, 11'h3FF, 57'h100000100000001, 3'b000, 64'h3F80000100000000, 3'b001, 1);
      send("sgl_carry", 0, 2'b00, 0, 11'h3FF, 57'h1FFFFFF00000000, 3'b000, 64'h4000000000000000, 3'b001, 1);
      send("sgl_ovf_rp", 0, 2'b10, 0, 11'h47F, 57'h100000000000000, 3'b000, 64'h7F80000000000000, 3'b101, 1);
      send("sgl_ovf_rm_pos", 0, 2'b11, 0, 11'h47F, 57'h100000000000000, 3'b000, 64'h7F7FFFFF00000000, 3'b101, 1);
      send("dbl_nan_over_inf", 1, 2'b00, 1, 11'h400, 57'h100000000000001, 3'b110, 64'h7FF8000000000000, 3'b000, 1);
      send("sgl_nan", 0, 2'b00, 0, 11'h400, 57'h100000000000000, 3'b100, 64'h7FC0000000000000, 3'b000, 1);
      send("dbl_inf_neg", 1, 2'b00, 1, 11'h7FF, 57'h100000000000001, 3'b011, 64'hFFF0000000000000, 3'b000, 1);
      send("sgl_inf_pos", 0, 2'b00, 0, 11'h000, 57'h0, 3'b010, 64'h7F80000000000000, 3'b000, 1);
      send("dbl_zero_flag", 1, 2'b00, 1, 11'h400, 57'h180000000000000, 3'b001, 64'h8000000000000000, 3'b000, 1);
      send("sgl_fs_zero", 0, 2'b10, 1, 11'h400, 57'h0, 3'b000, 64'h8000000000000000, 3'b000, 1);
      drain("directed");

      // Back-pressure: result holds steady while out_ready is low.
      out_ready = 1'b0;
      send("nan_hold", 1, 2'b00, 0, 11'h400, 57'h100000000000000, 3'b100, 64'h7FF8000000000000, 3'b000, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("hold_state", {in_ready, out_valid, fp_out}, {1'b0, 1'b1, 64'h7FF8000000000000});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release_idle", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});
      drain("hold");

      // Reset in PCK throws the operand away.
      send("rst_pck", 1, 2'b00, 0, 11'h400, 57'h180000000000000, 3'b000, 64'h0, 3'b000, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", {in_ready, out_valid, ovf, unf, inx, fp_out}, {1'b1, 4'b0000, 64'd0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
      end
      check("rst_no_output", {63'd0, out_valid}, 64'd0);

      send("post_rst", 1, 2'b00, 0, 11'h400, 57'h180000000000000, 3'b000, 64'h4008000000000000, 3'b000, 1);
      drain("final");
      check("output_count", 64'(n_out), 64'd28);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
